// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through data cache with one-word lines, byte ops and a refill FSM.
// Define DCACHE_FLUSH_EN to add the flush port and the sequential invalidate (FLUSH) state.
module dcache_dm #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         LINES      = 32,
    parameter logic [4:0] STR_UOP    = 5'b01001,
    parameter logic [4:0] LDR_UOP    = 5'b01010,
    parameter logic [4:0] STRB_UOP   = 5'b01011,
    parameter logic [4:0] LDRB_UOP   = 5'b01100
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            uop,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    output logic                  resp_valid,
    output logic [31:0]           data_out,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_rdata
`ifdef DCACHE_FLUSH_EN
    ,
    input  logic                  flush
`endif
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

`ifdef DCACHE_FLUSH_EN
    typedef enum logic [2:0] {IDLE, MISS_REQ, MISS_WAIT, WR_REQ, RESP, FLUSH} state_t;
`else
    typedef enum logic [2:0] {IDLE, MISS_REQ, MISS_WAIT, WR_REQ, RESP} state_t;
`endif
    state_t state;

    logic [LINES-1:0]      valid_bits;
    logic [TAG_BITS-1:0]   tag_array  [LINES];
    logic [31:0]           data_array [LINES];

    logic [TAG_BITS-1:0]   req_tag, tag_q;
    logic [INDEX_BITS-1:0] req_index, index_q;
    logic [1:0]            req_lane, lane_q;
    logic                  byte_q;
    logic [31:0]           line_word;
    logic                  hit, accept, flush_req, is_store;
    logic [31:0]           st_wdata;
    logic [3:0]            st_be;
    logic                  arr_we;
    logic [INDEX_BITS-1:0] arr_index;
    logic [TAG_BITS-1:0]   arr_tag;
    logic [31:0]           arr_data;
`ifdef DCACHE_FLUSH_EN
    logic [INDEX_BITS-1:0] flush_idx;
`endif

    function automatic logic [31:0] load_result(input logic [31:0] word, input logic is_byte,
                                                input logic [1:0] lane);
        logic [31:0] r;
        if (is_byte) r = {24'd0, word[lane*8 +: 8]};
        else         r = word;
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old_word[b*8 +: 8];
        return r;
    endfunction

`ifdef DCACHE_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign req_tag   = addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign req_index = addr[INDEX_BITS+1:2];
    assign req_lane  = addr[1:0];
    assign line_word = data_array[req_index];
    assign hit       = valid_bits[req_index] && (tag_array[req_index] == req_tag);
    assign req_ready = reset_n && (state == IDLE) && !flush_req;
    assign accept    = req_valid && req_ready;
    assign is_store  = (uop == STR_UOP) || (uop == STRB_UOP);

    always_comb begin
        st_wdata = data_in;
        st_be    = 4'hF;
        if (uop == STRB_UOP) begin
            st_wdata = {4{data_in[7:0]}};
            st_be    = 4'b0001 << req_lane;
        end
    end

    // Array write port: store-hit merge at acceptance, or refill on the memory response.
    always_comb begin
        arr_we    = 1'b0;
        arr_index = req_index;
        arr_tag   = req_tag;
        arr_data  = store_merge(line_word, st_wdata, st_be);
        if (accept && is_store && hit) begin
            arr_we = 1'b1;
        end else if (state == MISS_WAIT && mem_resp_valid) begin
            arr_we    = 1'b1;
            arr_index = index_q;
            arr_tag   = tag_q;
            arr_data  = mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (arr_we) begin
            tag_array[arr_index]  <= arr_tag;
            data_array[arr_index] <= arr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            valid_bits    <= '0;
            resp_valid    <= 1'b0;
            data_out      <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            tag_q         <= '0;
            index_q       <= '0;
            lane_q        <= '0;
            byte_q        <= 1'b0;
`ifdef DCACHE_FLUSH_EN
            flush_idx     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef DCACHE_FLUSH_EN
                    if (flush) begin
                        valid_bits[0] <= 1'b0;
                        flush_idx     <= INDEX_BITS'(1);
                        state         <= FLUSH;
                    end else
`endif
                    if (accept) begin
                        tag_q    <= req_tag;
                        index_q  <= req_index;
                        lane_q   <= req_lane;
                        byte_q   <= (uop == LDRB_UOP);
                        mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        case (uop)
                            LDR_UOP, LDRB_UOP: begin
                                if (hit) begin
                                    resp_valid <= 1'b1;
                                    data_out   <= load_result(line_word, uop == LDRB_UOP, req_lane);
                                    state      <= RESP;
                                end else begin
                                    mem_req_valid <= 1'b1;
                                    mem_we        <= 1'b0;
                                    mem_wdata     <= '0;
                                    mem_be        <= 4'h0;
                                    state         <= MISS_REQ;
                                end
                            end
                            STR_UOP, STRB_UOP: begin
                                mem_req_valid <= 1'b1;
                                mem_we        <= 1'b1;
                                mem_wdata     <= st_wdata;
                                mem_be        <= st_be;
                                state         <= WR_REQ;
                            end
                            default: begin
                                resp_valid <= 1'b1;
                                data_out   <= '0;
                                state      <= RESP;
                            end
                        endcase
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_bits[index_q] <= 1'b1;
                        resp_valid          <= 1'b1;
                        data_out            <= load_result(mem_rdata, byte_q, lane_q);
                        state               <= RESP;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        data_out      <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    data_out   <= '0;
                    state      <= IDLE;
                end
`ifdef DCACHE_FLUSH_EN
                FLUSH: begin
                    valid_bits[flush_idx] <= 1'b0;
                    flush_idx             <= flush_idx + 1'b1;
                    if (flush_idx == INDEX_BITS'(LINES - 1)) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
